// File: rtl/lock_ctrl4.sv
// Four-digit code lock: assembles keypad digits, compares against a stored password,
// and manages open/auto-relock, password change, failed-attempt counting and alarm lockout.
module lock_ctrl4 #(
    parameter logic [15:0]        DEFAULT_PW     = 16'h1234,
    parameter int                 MAX_ERR        = 3,
    parameter int                 TIMER_W        = 24,
    parameter logic [TIMER_W-1:0] OPEN_CYCLES    = 24'd5_000_000,
    parameter logic [TIMER_W-1:0] LOCKOUT_CYCLES = 24'd15_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        unlocked,
    output logic        alarm,
    output logic [2:0]  digit_cnt,
    output logic [1:0]  err_cnt,
    output logic [15:0] disp_digits,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_LOCKED = 3'd0,
        S_OPEN   = 3'd1,
        S_SET    = 3'd2,
        S_ALARM  = 3'd3
    } state_t;

    localparam logic [1:0]         MAX_ERR_L   = 2'(MAX_ERR);
    localparam logic [TIMER_W-1:0] OPEN_LOAD   = OPEN_CYCLES - 1'b1;
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = LOCKOUT_CYCLES - 1'b1;

    state_t             r_state,    w_state;
    logic [15:0]        r_pw,       w_pw;
    logic [15:0]        r_buf,      w_buf;
    logic [2:0]         r_cnt,      w_cnt;
    logic [1:0]         r_err,      w_err;
    logic [TIMER_W-1:0] r_timer,    w_timer;
    logic               r_unlocked, w_unlocked;
    logic               r_alarm,    w_alarm;

    logic        w_digit, w_enter, w_clear, w_lock, w_set;
    logic        w_full, w_match, w_timer_zero;
    logic [1:0]  w_err_inc;
    logic [15:0] w_ins_buf;

    assign w_digit      = key_valid && (key_code <= 4'd9);
    assign w_enter      = key_valid && (key_code == 4'hA);
    assign w_clear      = key_valid && (key_code == 4'hB);
    assign w_lock       = key_valid && (key_code == 4'hC);
    assign w_set        = key_valid && (key_code == 4'hD);
    assign w_full       = (r_cnt == 3'd4);
    assign w_match      = w_full && (r_buf == r_pw);
    assign w_timer_zero = (r_timer == '0);
    assign w_err_inc    = r_err + 2'd1;

    // Buffer with the incoming digit written into slot r_cnt (digit 0 is the MS nibble).
    always_comb begin
        w_ins_buf = r_buf;
        case (r_cnt)
            3'd0:    w_ins_buf[15:12] = key_code;
            3'd1:    w_ins_buf[11:8]  = key_code;
            3'd2:    w_ins_buf[7:4]   = key_code;
            3'd3:    w_ins_buf[3:0]   = key_code;
            default: w_ins_buf        = r_buf;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        w_state = r_state;
        w_pw    = r_pw;
        w_buf   = r_buf;
        w_cnt   = r_cnt;
        w_err   = r_err;
        w_timer = r_timer;

        case (r_state)
            S_LOCKED: begin
                if (w_digit && !w_full) begin
                    w_buf = w_ins_buf;
                    w_cnt = r_cnt + 3'd1;
                end else if (w_clear) begin
                    w_buf = '0;
                    w_cnt = '0;
                end else if (w_enter) begin
                    w_buf = '0;
                    w_cnt = '0;
                    if (w_match) begin
                        w_state = S_OPEN;
                        w_err   = '0;
                        w_timer = OPEN_LOAD;
                    end else if (w_err_inc == MAX_ERR_L) begin
                        w_state = S_ALARM;
                        w_err   = MAX_ERR_L;
                        w_timer = LOCKOUT_LOAD;
                    end else begin
                        w_err = w_err_inc;
                    end
                end
            end
            S_OPEN: begin
                // Expiry and LOCK both relock; the timer is parked at zero while locked.
                if (w_timer_zero || w_lock) begin
                    w_state = S_LOCKED;
                    w_timer = '0;
                end else if (w_set) begin
                    w_state = S_SET;
                    w_buf   = '0;
                    w_cnt   = '0;
                end else begin
                    w_timer = r_timer - 1'b1;
                end
            end
            S_SET: begin
                if (w_digit && !w_full) begin
                    w_buf = w_ins_buf;
                    w_cnt = r_cnt + 3'd1;
                end else if (w_clear) begin
                    w_buf = '0;
                    w_cnt = '0;
                end else if (w_enter) begin
                    if (w_full) w_pw = r_buf;
                    w_state = S_OPEN;
                    w_timer = OPEN_LOAD;
                    w_buf   = '0;
                    w_cnt   = '0;
                end else if (w_lock) begin
                    w_state = S_LOCKED;
                    w_timer = '0;
                    w_buf   = '0;
                    w_cnt   = '0;
                end
            end
            S_ALARM: begin
                w_buf = '0;
                w_cnt = '0;
                if (w_timer_zero) begin
                    w_state = S_LOCKED;
                    w_err   = '0;
                end else begin
                    w_timer = r_timer - 1'b1;
                end
            end
            default: begin
                w_state = S_LOCKED;
                w_buf   = '0;
                w_cnt   = '0;
                w_timer = '0;
            end
        endcase

        w_unlocked = (w_state == S_OPEN) || (w_state == S_SET);
        w_alarm    = (w_state == S_ALARM);
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_LOCKED;
            r_pw       <= DEFAULT_PW;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_err      <= '0;
            r_timer    <= '0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pw       <= w_pw;
            r_buf      <= w_buf;
            r_cnt      <= w_cnt;
            r_err      <= w_err;
            r_timer    <= w_timer;
            r_unlocked <= w_unlocked;
            r_alarm    <= w_alarm;
        end
    end

    assign unlocked    = r_unlocked;
    assign alarm       = r_alarm;
    assign digit_cnt   = r_cnt;
    assign err_cnt     = r_err;
    assign disp_digits = r_buf;
    assign state_o     = r_state;

endmodule

// File: tb/tb_lock_ctrl4.sv
// Bench for lock_ctrl4: directed scenarios plus random keys, every cycle compared against
// a digit-queue reference model of the lock behaviour.
module tb_lock_ctrl4;

    localparam int OPEN_N = 20;
    localparam int LOCK_N = 50;
    localparam int MAXE   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        unlocked, alarm;
    logic [2:0]  digit_cnt;
    logic [1:0]  err_cnt;
    logic [15:0] disp_digits;
    logic [2:0]  state_o;

    int n_pass = 0;
    int n_total = 0;

    lock_ctrl4 #(
        .DEFAULT_PW    (16'h1234),
        .MAX_ERR       (MAXE),
        .TIMER_W       (24),
        .OPEN_CYCLES   (24'(OPEN_N)),
        .LOCKOUT_CYCLES(24'(LOCK_N))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .digit_cnt  (digit_cnt),
        .err_cnt    (err_cnt),
        .disp_digits(disp_digits),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 locked, 1 open, 2 set, 3 alarm; digits kept as a queue.
    int m_mode;
    int m_q[$];
    int m_pw[4];
    int m_err;
    int m_left;

    function automatic void model_reset();
        m_mode = 0;
        m_q.delete();
        m_pw[0] = 1; m_pw[1] = 2; m_pw[2] = 3; m_pw[3] = 4;
        m_err  = 0;
        m_left = 0;
    endfunction

    function automatic bit model_match();
        if (m_q.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(logic rst, logic v, int c);
        bit dig, ent, clr, lck, st;
        if (rst) begin
            model_reset();
            return;
        end
        dig = v && c <= 9;
        ent = v && c == 10;
        clr = v && c == 11;
        lck = v && c == 12;
        st  = v && c == 13;
        case (m_mode)
            0: begin
                if (dig) begin
                    if (m_q.size() < 4) m_q.push_back(c);
                end else if (clr) m_q.delete();
                else if (ent) begin
                    if (model_match()) begin
                        m_mode = 1; m_err = 0; m_left = OPEN_N - 1;
                    end else begin
                        m_err++;
                        if (m_err == MAXE) begin
                            m_mode = 3; m_left = LOCK_N - 1;
                        end
                    end
                    m_q.delete();
                end
            end
            1: begin
                if (m_left == 0 || lck) m_mode = 0;
                else if (st) begin
                    m_mode = 2; m_q.delete();
                end else m_left--;
            end
            2: begin
                if (dig) begin
                    if (m_q.size() < 4) m_q.push_back(c);
                end else if (clr) m_q.delete();
                else if (ent) begin
                    if (m_q.size() == 4) for (int i = 0; i < 4; i++) m_pw[i] = m_q[i];
                    m_q.delete(); m_mode = 1; m_left = OPEN_N - 1;
                end else if (lck) begin
                    m_q.delete(); m_mode = 0;
                end
            end
            default: begin
                if (m_left == 0) begin
                    m_mode = 0; m_err = 0;
                end else m_left--;
            end
        endcase
    endfunction

    function automatic logic [15:0] model_disp();
        logic [15:0] d = '0;
        for (int i = 0; i < m_q.size(); i++) d = d | (16'(m_q[i]) << (12 - 4 * i));
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all();
        check("state_o", 32'(state_o), 32'(m_mode));
        check("unlocked", 32'(unlocked), 32'(m_mode == 1 || m_mode == 2));
        check("alarm", 32'(alarm), 32'(m_mode == 3));
        check("digit_cnt", 32'(digit_cnt), 32'(m_q.size()));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("disp_digits", 32'(disp_digits), 32'(model_disp()));
    endtask

    // One clock edge with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic tick(input logic v, input int c, input logic rst);
        key_valid = v;
        key_code  = 4'(c);
        reset     = rst;
        @(posedge clk);
        model_edge(rst, v, c);
        #1;
        check_all();
        key_valid = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic kp(input int c);
        tick(1'b1, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
    endtask

    task automatic keys(input int a, input int b, input int c, input int d, input int e);
        kp(a); kp(b); kp(c); kp(d); kp(e);
    endtask

    initial begin
        model_reset();
        tick(1'b0, 0, 1'b1);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_disp", 32'(disp_digits), 32'd0);

        // Default password opens, auto-relock 20 cycles after the ENTER edge.
        keys(1, 2, 3, 4, 10);
        check("open_unlocked", 32'(unlocked), 32'd1);
        check("open_state", 32'(state_o), 32'd1);
        idle(OPEN_N - 1);
        check("open_last_cycle", 32'(unlocked), 32'd1);
        idle(1);
        check("relock", 32'(unlocked), 32'd0);

        // Three failures trigger the alarm; keys ignored during lockout.
        keys(1, 2, 3, 5, 10);
        check("err1", 32'(err_cnt), 32'd1);
        keys(1, 2, 3, 5, 10);
        check("err2", 32'(err_cnt), 32'd2);
        keys(1, 2, 3, 5, 10);
        check("alarm_on", 32'(alarm), 32'd1);
        keys(1, 2, 3, 4, 10);
        check("alarm_ignores", 32'(state_o), 32'd3);
        idle(LOCK_N - 6);
        check("alarm_last_cycle", 32'(alarm), 32'd1);
        idle(1);
        check("alarm_off", 32'(alarm), 32'd0);
        check("alarm_err_clr", 32'(err_cnt), 32'd0);

        // CLEAR and buffer-full behaviour.
        kp(1); kp(2); kp(11);
        check("clear_cnt", 32'(digit_cnt), 32'd0);
        keys(9, 8, 7, 6, 5);
        check("full_disp", 32'(disp_digits), 32'h9876);
        check("full_cnt", 32'(digit_cnt), 32'd4);
        kp(10);
        check("full_fail", 32'(err_cnt), 32'd1);

        // Password change to 5678.
        keys(1, 2, 3, 4, 10);
        kp(13); keys(5, 6, 7, 8, 10); kp(12);
        check("set_locked", 32'(state_o), 32'd0);
        keys(1, 2, 3, 4, 10);
        check("old_pw_fails", 32'(err_cnt), 32'd1);
        keys(5, 6, 7, 8, 10);
        check("new_pw_opens", 32'(state_o), 32'd1);

        // Aborted SET, then reset while in SET restores the default password.
        kp(13); kp(1); kp(2); kp(10);
        check("abort_open", 32'(state_o), 32'd1);
        kp(13);
        check("in_set", 32'(state_o), 32'd2);
        tick(1'b0, 0, 1'b1);
        check("set_reset", 32'(state_o), 32'd0);
        keys(1, 2, 3, 4, 10);
        check("default_again", 32'(unlocked), 32'd1);

        // Randomized keys with occasional correct-password bursts and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 40) == 0)
                keys(m_pw[0], m_pw[1], m_pw[2], m_pw[3], 10);
            else if ($urandom_range(0, 300) == 0)
                tick(1'b0, 0, 1'b1);
            else if ($urandom_range(0, 1) == 0)
                tick(1'b1, ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8))
                                                        : int'($urandom_range(0, 15)), 1'b0);
            else
                tick(1'b0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
